pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, optional two-entry skid buffer, flush and bubble insertion. It is the general replacement for the fixed-field inter-stage latches between ID/EX, EX/MEM and MEM/WB in the CPU pipeline. Datapath, control and destination-register fields are carried as separate buses so that bubbles and flushes can clear control without touching data. Stall propagates backwards through `in_ready`, so the hazard unit only needs to drive `out_ready` of the stalled stage.

## Interface
Parameters:
- `DATA_W`, 64: payload width (e.g. ALUout ++ busB).
- `CTRL_W`, 5: control field width (e.g. MemOp, MemtoReg, MemWr); forced to 0 in bubbles.
- `RD_W`, 5: destination register index width.
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.

Ports:
- `clock`  in  1  single clock; all state updates on the falling edge, matching the other pipeline registers.
- `reset`  in  1  synchronous, active-high; sampled on the falling edge of `clock`.
- `flush`  in  1  discard all held entries at the next edge.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `in_data`  in  DATA_W  payload.
- `in_ctrl`  in  CTRL_W  control bits.
- `in_rd`  in  RD_W  destination register.
- `in_regwr`  in  1  register-write enable.
- `out_valid`  out  1  entry presented downstream.
- `out_ready`  in  1  downstream accepts; 0 = stall.
- `out_data`  out  DATA_W
- `out_ctrl`  out  CTRL_W
- `out_rd`  out  RD_W
- `out_regwr`  out  1
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- Accept: `in_valid & in_ready`. Release: `out_valid & out_ready`.
- Stored rd = `in_rd & {RD_W{in_regwr}}`, so an entry that does not write a register always carries rd 0. Forwarding logic relies on this.
- When `out_valid`=0 (bubble), `out_ctrl`, `out_rd` and `out_regwr` are 0. `out_data` holds its last value.
- SKID=1 has a main register (drives outputs) and a skid register. `in_ready` = !skid_valid and is registered.
  - Main empty, or main releasing with skid empty: the accepted entry loads main.
  - Main full, not releasing, entry accepted: the entry loads skid.
  - Main releasing with skid full: skid moves to main and skid empties. No accept is possible, because `in_ready`=0.
  - Entries leave in the order they were accepted.
- SKID=0: `in_ready` = !out_valid | out_ready (combinational). Main loads on accept and empties on release without a new accept.
- `flush`: main and skid are both invalidated at the next edge, and an accept in the same cycle is discarded. A release in the same cycle is still considered delivered downstream.
- Priority: reset > flush > release/accept.
- `occupancy` = main_valid + skid_valid (registered).

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_ctrl`=0, `out_rd`=0, `out_regwr`=0, `occupancy`=0.
  - Skid is empty.
  - `in_ready` is forced to 0 while `reset`=1, and is 1 in the first cycle after reset deasserts.
- Reset mid-operation drops all held entries with no release.
- Latency is one falling edge from accept to `out_valid`=1 with that entry.
- Throughput is one entry per cycle while `out_ready`=1, for both SKID settings.
- SKID=1 full condition: occupancy 2 means `in_ready`=0 in the following cycle. After one release, `in_ready` returns to 1 one edge later.
- Empty condition: with occupancy 0, `out_valid`=0 regardless of `out_ready`.
- Stall: while `out_ready`=0, all outputs hold stable, and `in_ready` only falls as a result of an edge.

## Test plan
- **Reset:** assert `reset` for 2 edges with `in_valid`=1 and `in_data`=64'hDEAD → all outputs 0, `in_ready`=0 during reset, `occupancy`=0 after reset; after deassertion `in_ready`=1.
- **Streaming and rd mask:** with `out_ready`=1, stream 4 entries with data 1..4 and `in_regwr` pattern 1,0,1,0 with `in_rd`=5'd7 → outputs data 1..4 on consecutive edges after one edge of latency, and `out_rd`=7,0,7,0.
- **Stall fill (SKID=1):** `out_ready`=0, present A then B then C → A held on outputs, `occupancy`=2, `in_ready`=0 while C is stalled. Raise `out_ready` → outputs A, B, C in order with no loss or duplication.
- **Flush:** with `occupancy`=2, assert `flush` together with `in_valid`=1 → next edge `out_valid`=0, `out_ctrl`=0, `out_rd`=0, `occupancy`=0, and the incoming entry is not stored.
- **SKID=0 stall:** `out_ready`=0 with an entry held → `in_ready`=0 in the same cycle. Assert `out_ready` and a new entry together → the new entry is accepted that cycle and appears after the next edge.
- **Reset mid-operation:** with 2 entries held, pulse `reset` for one edge → `occupancy`=0, no entry is released, and the stage resumes streaming normally.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
// Valid/ready handshake bundle that carries one pipeline entry between stages.
// Data, control and destination-register fields travel separately so that a
// bubble can clear control without touching the datapath bits.
//
// Signals:
//   valid  producer -> consumer  entry present
//   ready  consumer -> producer  entry can be taken this cycle
//   data   producer -> consumer  DATA_W payload
//   ctrl   producer -> consumer  CTRL_W control bits
//   rd     producer -> consumer  RD_W destination register index
//   regwr  producer -> consumer  register-write enable
//
// Modports:
//   master  drives the entry, observes ready (upstream side of a link)
//   slave   observes the entry, drives ready (downstream side of a link)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 5,
    parameter int RD_W   = 5
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic              regwr;

    modport master (
        output valid,
        output data,
        output ctrl,
        output rd,
        output regwr,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        input  rd,
        input  regwr,
        output ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, flush and bubble insertion. All state updates on the falling edge of
// clock, like the other inter-stage latches of the CPU pipeline.
//
// Ports:
//   clock      in   single clock, state updates on the falling edge
//   reset      in   synchronous active-high reset, sampled on the falling edge
//   flush      in   drop every held entry (and any same-cycle accept)
//   up         slave  upstream link: valid/data/ctrl/rd/regwr in, ready out
//   dn         master downstream link: valid/data/ctrl/rd/regwr out, ready in
//   occupancy  out  number of held entries, 0..2
//
// Parameters:
//   DATA_W, CTRL_W, RD_W  field widths (must match the connected interfaces)
//   SKID  1: main + skid register, ready registered (from skid_valid)
//         0: single register, ready combinational from the downstream stall
//
// Holding states (main_valid, skid_valid):
//   state | meaning
//   0 0   | empty, outputs show a bubble
//   1 0   | one entry, presented downstream
//   1 1   | full (SKID=1 only), upstream ready is low
//   0 1   | unreachable: skid always drains into main first
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 5,
    parameter int RD_W   = 5,
    parameter int SKID   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    pipe_stage_reg_if.slave     up,
    pipe_stage_reg_if.master    dn,
    output logic [1:0]          occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [RD_W-1:0]   rd;
        logic              regwr;
    } entry_t;

    logic   main_valid;
    logic   skid_valid;
    entry_t main_q;
    entry_t skid_q;
    logic [1:0] occ_q;

    logic   main_valid_n;
    logic   skid_valid_n;
    entry_t main_n;
    entry_t skid_n;

    entry_t in_entry;
    logic   in_ready;
    logic   accept;
    logic   release_dn;

    // An entry that does not write a register must carry rd 0; the
    // forwarding comparators downstream depend on it.
    always_comb begin
        in_entry.data  = up.data;
        in_entry.ctrl  = up.ctrl;
        in_entry.rd    = up.rd & {RD_W{up.regwr}};
        in_entry.regwr = up.regwr;
    end

    // With the skid buffer, ready comes straight from a flop so the stall
    // path does not ripple combinationally through a chain of stages.
    // Reset gating lets ready rise in the first cycle after reset.
    always_comb begin
        if (SKID != 0) begin
            in_ready = !skid_valid;
        end else begin
            in_ready = !main_valid || dn.ready;
        end
        if (reset) begin
            in_ready = 1'b0;
        end
    end

    assign accept     = up.valid && in_ready;
    assign release_dn = main_valid && dn.ready;

    always_comb begin
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        main_n       = main_q;
        skid_n       = skid_q;

        if (flush) begin
            // Data is left alone; only the fields that matter to later
            // stages are cleared. A same-cycle accept is simply not taken.
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
            main_n.ctrl  = '0;
            main_n.rd    = '0;
            main_n.regwr = 1'b0;
        end else if (!main_valid || release_dn) begin
            if (skid_valid) begin
                // ready is low here, so no accept competes for main.
                main_valid_n = 1'b1;
                main_n       = skid_q;
                skid_valid_n = 1'b0;
            end else if (accept) begin
                main_valid_n = 1'b1;
                main_n       = in_entry;
            end else begin
                main_valid_n = 1'b0;
                main_n.ctrl  = '0;
                main_n.rd    = '0;
                main_n.regwr = 1'b0;
            end
        end else if (accept && (SKID != 0)) begin
            skid_valid_n = 1'b1;
            skid_n       = in_entry;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            occ_q      <= 2'd0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            main_q     <= main_n;
            skid_q     <= skid_n;
            occ_q      <= {1'b0, main_valid_n} + {1'b0, skid_valid_n};
        end
    end

    assign up.ready  = in_ready;

    // ctrl/rd/regwr registers are cleared whenever main goes empty, so the
    // outputs already read as a bubble without extra gating.
    assign dn.valid  = main_valid;
    assign dn.data   = main_q.data;
    assign dn.ctrl   = main_q.ctrl;
    assign dn.rd     = main_q.rd;
    assign dn.regwr  = main_q.regwr;

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Scoreboard bench for pipe_stage_reg. Two instances run side by side:
// u_a with the skid buffer and u_b without. Inputs change at posedge+1,
// accepted entries are pushed at posedge+2, the output monitors pop and
// compare at posedge+3 and directed checks sit at posedge+4; the DUT updates
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  ctrl;
        logic [4:0]  rd;
        logic        regwr;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  ctrl;
        logic [4:0]  rd;
        logic        regwr;
        logic [4:0]  exp_rd;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] a_occ;
    logic [1:0] b_occ;

    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(5), .RD_W(5)) a_up ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(5), .RD_W(5)) a_dn ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(5), .RD_W(5)) b_up ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(5), .RD_W(5)) b_dn ();

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(5), .RD_W(5), .SKID(1)) u_a (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .up        (a_up),
        .dn        (a_dn),
        .occupancy (a_occ)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(5), .RD_W(5), .SKID(0)) u_b (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .up        (b_up),
        .dn        (b_dn),
        .occupancy (b_occ)
    );

    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t a_exp;
    exp_t b_exp;
    exp_t ea;
    exp_t eb;
    int   a_rel = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] d, input logic [4:0] c,
                                input logic [4:0] r, input logic w, input logic [4:0] er);
        vec_t v;
        v.data = d; v.ctrl = c; v.rd = r; v.regwr = w; v.exp_rd = er;
        return v;
    endfunction

    task automatic set_a(input logic v, input vec_t x);
        a_up.valid = v;
        a_up.data  = x.data;
        a_up.ctrl  = x.ctrl;
        a_up.rd    = x.rd;
        a_up.regwr = x.regwr;
        a_exp      = '{x.data, x.ctrl, x.exp_rd, x.regwr};
    endtask

    task automatic set_b(input logic v, input vec_t x);
        b_up.valid = v;
        b_up.data  = x.data;
        b_up.ctrl  = x.ctrl;
        b_up.rd    = x.rd;
        b_up.regwr = x.regwr;
        b_exp      = '{x.data, x.ctrl, x.exp_rd, x.regwr};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard push: an entry offered while the stage is ready is owed
    // downstream unless the same cycle flushes or resets.
    always @(posedge clock) begin
        #2;
        if (!reset && !flush && a_up.valid && a_up.ready) qa.push_back(a_exp);
        if (!reset && !flush && b_up.valid && b_up.ready) qb.push_back(b_exp);
    end

    // Output monitors.
    always @(posedge clock) begin
        #3;
        if (a_dn.valid && a_dn.ready) begin
            a_rel++;
            if (qa.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL a_unexpected_release: got data %0h, required no release", a_dn.data);
            end else begin
                ea = qa.pop_front();
                check("a_data",  a_dn.data,  ea.data);
                check("a_ctrl",  64'(a_dn.ctrl),  64'(ea.ctrl));
                check("a_rd",    64'(a_dn.rd),    64'(ea.rd));
                check("a_regwr", 64'(a_dn.regwr), 64'(ea.regwr));
            end
        end else if (!a_dn.valid && !reset) begin
            check("a_bubble_fields", 64'({a_dn.ctrl, a_dn.rd, a_dn.regwr}), 64'd0);
        end

        if (b_dn.valid && b_dn.ready) begin
            if (qb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL b_unexpected_release: got data %0h, required no release", b_dn.data);
            end else begin
                eb = qb.pop_front();
                check("b_data",  b_dn.data,  eb.data);
                check("b_ctrl",  64'(b_dn.ctrl),  64'(eb.ctrl));
                check("b_rd",    64'(b_dn.rd),    64'(eb.rd));
                check("b_regwr", 64'(b_dn.regwr), 64'(eb.regwr));
            end
        end else if (!b_dn.valid && !reset) begin
            check("b_bubble_fields", 64'({b_dn.ctrl, b_dn.rd, b_dn.regwr}), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t zero_v;
    vec_t stream_v [4];
    int   rel_start;

    initial begin
        zero_v      = mk(64'h0, 5'h0, 5'h0, 1'b0, 5'h0);
        stream_v[0] = mk(64'd1, 5'h01, 5'd7, 1'b1, 5'd7);
        stream_v[1] = mk(64'd2, 5'h02, 5'd7, 1'b0, 5'd0);
        stream_v[2] = mk(64'd3, 5'h03, 5'd7, 1'b1, 5'd7);
        stream_v[3] = mk(64'd4, 5'h04, 5'd7, 1'b0, 5'd0);

        // ---------------- reset with an entry offered ----------------
        reset = 1'b1;
        flush = 1'b0;
        set_a(1'b1, mk(64'hDEAD, 5'h1F, 5'd9, 1'b1, 5'd9));
        set_b(1'b1, mk(64'hDEAD, 5'h1F, 5'd9, 1'b1, 5'd9));
        a_dn.ready = 1'b1;
        b_dn.ready = 1'b1;
        step();
        step();
        #3;
        check("rst_a_in_ready",  64'(a_up.ready), 64'd0);
        check("rst_b_in_ready",  64'(b_up.ready), 64'd0);
        check("rst_a_out_valid", 64'(a_dn.valid), 64'd0);
        check("rst_a_out_data",  a_dn.data, 64'd0);
        check("rst_a_out_ctrl",  64'(a_dn.ctrl), 64'd0);
        check("rst_a_out_rd",    64'(a_dn.rd), 64'd0);
        check("rst_a_out_regwr", 64'(a_dn.regwr), 64'd0);
        check("rst_a_occ",       64'(a_occ), 64'd0);
        check("rst_b_out_valid", 64'(b_dn.valid), 64'd0);
        check("rst_b_out_data",  b_dn.data, 64'd0);
        step();
        reset = 1'b0;
        set_a(1'b0, zero_v);
        set_b(1'b0, zero_v);
        #3;
        check("post_rst_a_in_ready", 64'(a_up.ready), 64'd1);
        check("post_rst_b_in_ready", 64'(b_up.ready), 64'd1);
        check("post_rst_a_occ",      64'(a_occ), 64'd0);
        check("post_rst_b_occ",      64'(b_occ), 64'd0);
        step();
        #3;
        check("post_rst_a_valid", 64'(a_dn.valid), 64'd0);

        // ---------------- streaming with rd mask, both instances ----------------
        rel_start = a_rel;
        for (int i = 0; i < 4; i++) begin
            step();
            set_a(1'b1, stream_v[i]);
            set_b(1'b1, stream_v[i]);
            #3;
            if (i > 0) begin
                check("stream_a_valid", 64'(a_dn.valid), 64'd1);
                check("stream_b_valid", 64'(b_dn.valid), 64'd1);
            end
        end
        step();
        set_a(1'b0, zero_v);
        set_b(1'b0, zero_v);
        #3;
        check("stream_a_last_valid", 64'(a_dn.valid), 64'd1);
        check("stream_a_last_data",  a_dn.data, 64'd4);
        step();
        #3;
        check("stream_a_releases", 64'(a_rel - rel_start), 64'd4);
        check("stream_a_drained",  64'(qa.size()), 64'd0);
        check("stream_b_drained",  64'(qb.size()), 64'd0);
        check("stream_a_empty",    64'(a_dn.valid), 64'd0);
        check("stream_a_data_hold", a_dn.data, 64'd4);

        // ---------------- stall fill on the skid instance ----------------
        step();
        a_dn.ready = 1'b0;
        set_a(1'b1, mk(64'hA, 5'h0A, 5'd3, 1'b1, 5'd3));
        #3;
        check("fill_ready_empty", 64'(a_up.ready), 64'd1);
        step();
        set_a(1'b1, mk(64'hB, 5'h0B, 5'd4, 1'b0, 5'd0));
        #3;
        check("fill_occ1",   64'(a_occ), 64'd1);
        check("fill_data_a", a_dn.data, 64'hA);
        check("fill_ready1", 64'(a_up.ready), 64'd1);
        step();
        set_a(1'b1, mk(64'hC, 5'h0C, 5'd5, 1'b1, 5'd5));
        #3;
        check("fill_occ2",     64'(a_occ), 64'd2);
        check("fill_ready_c",  64'(a_up.ready), 64'd0);
        check("fill_data_a2",  a_dn.data, 64'hA);
        step();
        #3;
        check("fill_hold_occ",   64'(a_occ), 64'd2);
        check("fill_hold_ready", 64'(a_up.ready), 64'd0);
        check("fill_hold_data",  a_dn.data, 64'hA);
        check("fill_hold_valid", 64'(a_dn.valid), 64'd1);
        step();
        a_dn.ready = 1'b1;
        #3;
        check("drain_ready_still_low", 64'(a_up.ready), 64'd0);
        step();
        #3;
        check("drain_ready_back", 64'(a_up.ready), 64'd1);
        check("drain_occ1",       64'(a_occ), 64'd1);
        step();
        set_a(1'b0, zero_v);
        #3;
        check("drain_data_c", a_dn.data, 64'hC);
        step();
        #3;
        check("drain_empty_q",   64'(qa.size()), 64'd0);
        check("drain_empty_occ", 64'(a_occ), 64'd0);

        // ---------------- flush while full ----------------
        step();
        a_dn.ready = 1'b0;
        set_a(1'b1, mk(64'hD, 5'h0D, 5'd6, 1'b1, 5'd6));
        step();
        set_a(1'b1, mk(64'hE, 5'h0E, 5'd8, 1'b1, 5'd8));
        step();
        set_a(1'b0, zero_v);
        #3;
        check("flush_pre_occ", 64'(a_occ), 64'd2);
        step();
        flush = 1'b1;
        set_a(1'b1, mk(64'hF, 5'h0F, 5'd9, 1'b1, 5'd9));
        qa.delete();
        step();
        flush = 1'b0;
        set_a(1'b0, zero_v);
        #3;
        check("flush_valid", 64'(a_dn.valid), 64'd0);
        check("flush_ctrl",  64'(a_dn.ctrl), 64'd0);
        check("flush_rd",    64'(a_dn.rd), 64'd0);
        check("flush_regwr", 64'(a_dn.regwr), 64'd0);
        check("flush_occ",   64'(a_occ), 64'd0);

        // flush with one entry held: here the concurrent offer would be
        // accepted, so its absence afterwards shows it was discarded
        step();
        set_a(1'b1, mk(64'h11, 5'h11, 5'd1, 1'b1, 5'd1));
        step();
        set_a(1'b0, zero_v);
        #3;
        check("flush2_pre_occ", 64'(a_occ), 64'd1);
        step();
        flush = 1'b1;
        set_a(1'b1, mk(64'h12, 5'h12, 5'd2, 1'b1, 5'd2));
        qa.delete();
        #3;
        check("flush2_in_ready", 64'(a_up.ready), 64'd1);
        step();
        flush = 1'b0;
        set_a(1'b0, zero_v);
        #3;
        check("flush2_occ",   64'(a_occ), 64'd0);
        check("flush2_valid", 64'(a_dn.valid), 64'd0);
        step();
        a_dn.ready = 1'b1;
        step();
        step();
        #3;
        check("flush2_nothing_out", 64'(a_dn.valid), 64'd0);

        // ---------------- SKID=0 stall ----------------
        step();
        b_dn.ready = 1'b0;
        set_b(1'b1, mk(64'h6, 5'h06, 5'd10, 1'b1, 5'd10));
        #3;
        check("b_ready_empty", 64'(b_up.ready), 64'd1);
        step();
        set_b(1'b0, zero_v);
        #3;
        check("b_stall_ready", 64'(b_up.ready), 64'd0);
        check("b_stall_occ",   64'(b_occ), 64'd1);
        check("b_stall_data",  b_dn.data, 64'h6);
        step();
        b_dn.ready = 1'b1;
        set_b(1'b1, mk(64'h7, 5'h07, 5'd11, 1'b0, 5'd0));
        #3;
        check("b_release_ready", 64'(b_up.ready), 64'd1);
        step();
        set_b(1'b0, zero_v);
        #3;
        check("b_new_valid", 64'(b_dn.valid), 64'd1);
        check("b_new_data",  b_dn.data, 64'h7);
        step();
        #3;
        check("b_drained", 64'(qb.size()), 64'd0);
        check("b_empty",   64'(b_dn.valid), 64'd0);

        // ---------------- reset mid-operation ----------------
        step();
        a_dn.ready = 1'b0;
        set_a(1'b1, mk(64'h21, 5'h01, 5'd12, 1'b1, 5'd12));
        step();
        set_a(1'b1, mk(64'h22, 5'h02, 5'd13, 1'b1, 5'd13));
        step();
        set_a(1'b0, zero_v);
        #3;
        check("mid_pre_occ", 64'(a_occ), 64'd2);
        step();
        reset = 1'b1;
        qa.delete();
        qb.delete();
        #3;
        check("mid_rst_in_ready", 64'(a_up.ready), 64'd0);
        step();
        reset = 1'b0;
        #3;
        check("mid_occ",      64'(a_occ), 64'd0);
        check("mid_valid",    64'(a_dn.valid), 64'd0);
        check("mid_in_ready", 64'(a_up.ready), 64'd1);
        rel_start = a_rel;
        step();
        a_dn.ready = 1'b1;
        step();
        #3;
        check("mid_no_release", 64'(a_rel - rel_start), 64'd0);
        step();
        set_a(1'b1, mk(64'h31, 5'h03, 5'd14, 1'b1, 5'd14));
        step();
        set_a(1'b1, mk(64'h32, 5'h04, 5'd15, 1'b0, 5'd0));
        step();
        set_a(1'b0, zero_v);
        #3;
        check("resume_valid", 64'(a_dn.valid), 64'd1);
        check("resume_data",  a_dn.data, 64'h32);
        step();
        #3;
        check("resume_releases", 64'(a_rel - rel_start), 64'd2);
        check("resume_drained",  64'(qa.size()), 64'd0);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
